// File: rtl/imem_loader.sv
// imem_loader: loads a framed, checksummed byte stream into instruction memory
//
// Frame: LEN_HI, LEN_LO, 4*N data bytes (big-endian words), XOR checksum byte.
// Words are written from address 0 upward; the CPU is held in reset until a
// frame completes with a matching checksum.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse starting a new load (honoured in IDLE/DONE/ERR)
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   loader accepts a byte (LEN_HI, LEN_LO, DATA, CSUM)
//   imw_we     registered write strobe to instruction memory
//   imw_addr   registered word address
//   imw_data   registered instruction word
//   cpu_hold   keeps the CPU in reset while high
//   load_done  last frame loaded with a good checksum
//   load_err   last frame was rejected
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imw_we,
    output logic [ADDR_W-1:0] imw_addr,
    output logic [31:0]       imw_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [16:0]     CAP  = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] WONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic [7:0]        len_hi, acc;
    logic [ADDR_W:0]   nwords, wcnt;
    logic [1:0]        bcnt;
    logic [23:0]       sh;
    logic [15:0]       n_full;
    logic              accept, restart, len_bad, last_byte;

    assign accept    = in_valid && in_ready;
    assign restart   = start && (state == IDLE || state == DONE || state == ERR);
    assign n_full    = {len_hi, in_data};
    assign len_bad   = n_full == '0 || {1'b0, n_full} > CAP;
    // Word counter is one bit wider than the address so N = 2**ADDR_W ends cleanly.
    assign last_byte = bcnt == 2'd3 && wcnt + WONE == nwords;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = state == LEN_HI || state == LEN_LO || state == DATA || state == CSUM;
        cpu_hold  = state != DONE;
        load_done = state == DONE;
        load_err  = state == ERR;
        case (state)
            IDLE, DONE, ERR: if (start)  state_nx = LEN_HI;
            LEN_HI:          if (accept) state_nx = LEN_LO;
            LEN_LO:          if (accept) state_nx = len_bad ? ERR : DATA;
            DATA:            if (accept && last_byte) state_nx = CSUM;
            CSUM:            if (accept) state_nx = in_data == acc ? DONE : ERR;
            default:         state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_hi   <= '0;
            acc      <= '0;
            nwords   <= '0;
            wcnt     <= '0;
            bcnt     <= '0;
            sh       <= '0;
            imw_we   <= 1'b0;
            imw_addr <= '0;
            imw_data <= '0;
        end else begin
            imw_we <= 1'b0;
            if (restart) begin
                wcnt <= '0;
                bcnt <= '0;
                acc  <= '0;
            end
            if (accept && state == LEN_HI) len_hi <= in_data;
            if (accept && state == LEN_LO) nwords <= n_full[ADDR_W:0];
            if (accept && state == DATA) begin
                sh   <= {sh[15:0], in_data};
                acc  <= acc ^ in_data;
                bcnt <= bcnt + 2'd1;
                if (bcnt == 2'd3) begin
                    imw_we   <= 1'b1;
                    imw_addr <= wcnt[ADDR_W-1:0];
                    imw_data <= {sh, in_data};
                    wcnt     <= wcnt + WONE;
                end
            end
        end
    end

endmodule
